alu_issue_ctrl: RTL and testbench

Multi-cycle issue/retire sequencer on the initiator side of the execute-stage ALU. Accepts one decoded operation per valid/ready handshake and translates `alu_op`/`funct3`/`funct7_5` into the 4-bit ALU control code. Drives registered operands to the ALU, captures `ALU_result`/`zero` one cycle later, derives the branch decision, and returns the result through an output valid/ready handshake. Sits between decode and writeback/PC-select.

---
 rtl/alu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/retire sequencer in front of the execute-stage ALU.
// Accepts one decoded op, drives registered operands + control code to the
// ALU, captures the ALU result one cycle later and hands it back through an
// output valid/ready handshake together with the branch decision.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic [31:0]       imm,
  output logic [31:0]       alu_op1,
  output logic [31:0]       alu_op2,
  output logic [3:0]        alu_control,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              branch_taken,
  output logic              illegal,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_GTE = 4'b0111;
  localparam logic [3:0] C_LTE = 4'b1001;

  state_t           state_q, state_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             is_br_q, is_br_d;   // op in flight is a legal branch
  logic             br_inv_q, br_inv_d; // taken on !zero (BNE)
  logic             ill_q, ill_d;       // op in flight decoded illegal
  logic [31:0]      result_q, result_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [3:0]       dec_ctrl;
  logic             dec_imm, dec_ill, dec_br, dec_inv;

  // Decode alu_op/funct3/funct7_5 into control code, operand source and branch sense
  always_comb begin
    dec_ctrl = C_ADD;
    dec_imm  = 1'b0;
    dec_ill  = 1'b0;
    dec_br   = 1'b0;
    dec_inv  = 1'b0;
    case (alu_op)
      2'b00: dec_imm = 1'b1;
      2'b01: begin
        dec_br = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = C_SUB;
          3'b001:  begin dec_ctrl = C_SUB; dec_inv = 1'b1; end
          3'b110:  dec_ctrl = C_LTE;
          3'b111:  dec_ctrl = C_GTE;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = funct7_5 ? C_SUB : C_ADD;
          3'b111:  dec_ctrl = C_AND;
          3'b110:  dec_ctrl = C_OR;
          3'b001:  begin dec_ctrl = C_SLL; dec_ill = funct7_5; end
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        dec_imm = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = C_ADD;
          3'b111:  dec_ctrl = C_AND;
          3'b110:  dec_ctrl = C_OR;
          3'b001:  begin dec_ctrl = C_SLL; dec_ill = funct7_5; end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
    // Illegal ops run as ADD 0+0 so the ALU stays quiet and timing is unchanged
    if (dec_ill) dec_ctrl = C_ADD;
  end

  // Sequencer next-state: latch decode in IDLE, capture in EXEC, retire in DONE
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ctrl_d     = ctrl_q;
    is_br_d    = is_br_q;
    br_inv_d   = br_inv_q;
    ill_d      = ill_q;
    result_d   = result_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op1_d    = dec_ill ? 32'h0 : rs1_data;
        op2_d    = dec_ill ? 32'h0 : (dec_imm ? imm : rs2_data);
        ctrl_d   = dec_ctrl;
        is_br_d  = dec_br & ~dec_ill;
        br_inv_d = dec_inv;
        ill_d    = dec_ill;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d  = ill_q ? 32'h0 : alu_result;
        taken_d   = is_br_q & (alu_zero ^ br_inv_q);
        illegal_d = ill_q;
        state_d   = S_DONE;
      end
      S_DONE: if (out_ready) begin
        op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      ctrl_q     <= '0;
      is_br_q    <= 1'b0;
      br_inv_q   <= 1'b0;
      ill_q      <= 1'b0;
      result_q   <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      ctrl_q     <= ctrl_d;
      is_br_q    <= is_br_d;
      br_inv_q   <= br_inv_d;
      ill_q      <= ill_d;
      result_q   <= result_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_control  = ctrl_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
// op_count is built 3 bits wide so the wrap to zero is reached quickly.
module tb_alu_issue_ctrl;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       alu_op = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7_5 = 1'b0;
  logic [31:0]      rs1_data = '0, rs2_data = '0, imm = '0;
  logic [31:0]      alu_op1, alu_op2;
  logic [3:0]       alu_control;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      result;
  logic             branch_taken;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  int errors = 0;
  int checks = 0;
  int cnt = 0;

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: compare codes return 0 (zero=1) when the relation holds
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b1000: alu_result = alu_op1 << alu_op2[4:0];
      4'b0111: alu_result = (alu_op1 >= alu_op2) ? 32'h0 : 32'h1;
      4'b1001: alu_result = (alu_op1 <= alu_op2) ? 32'h0 : 32'h1;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full op with out_ready held high: accept, capture, retire
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [3:0] e_ctrl,
                        input logic [31:0] e_res, input logic e_bt, input logic e_ill);
    @(negedge clk);
    alu_op = aop; funct3 = f3; funct7_5 = f7;
    rs1_data = a; rs2_data = b; imm = im; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".in_ready_t0"}, {31'h0, in_ready}, 32'h0);
    check({tag, ".ctrl"}, {28'h0, alu_control}, {28'h0, e_ctrl});
    @(posedge clk); #1;
    check({tag, ".out_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, ".result"}, result, e_res);
    check({tag, ".taken"}, {31'h0, branch_taken}, {31'h0, e_bt});
    check({tag, ".illegal"}, {31'h0, illegal}, {31'h0, e_ill});
    @(posedge clk); #1;
    cnt = (cnt + 1) % 8;
    check({tag, ".op_count"}, {29'h0, op_count}, cnt[31:0]);
    check({tag, ".in_ready_after"}, {31'h0, in_ready}, 32'h1);
    check({tag, ".out_valid_after"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.in_ready", {31'h0, in_ready}, 32'h1);
    check("rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst.ctrl", {28'h0, alu_control}, 32'h0);
    check("rst.result", result, 32'h0);
    check("rst.op_count", {29'h0, op_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("rsub",  2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 4'b0110, 32'd7, 1'b0, 1'b0);
    run_op("beq",   2'b01, 3'b000, 1'b0, 32'h55, 32'h55, 32'h0, 4'b0110, 32'h0, 1'b1, 1'b0);
    run_op("bne",   2'b01, 3'b001, 1'b0, 32'h55, 32'h55, 32'h0, 4'b0110, 32'h0, 1'b0, 1'b0);
    run_op("bltu",  2'b01, 3'b110, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'b1001, 32'h0, 1'b1, 1'b0);
    run_op("bgeu",  2'b01, 3'b111, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'b0111, 32'h1, 1'b0, 1'b0);
    run_op("islli", 2'b11, 3'b001, 1'b0, 32'h1, 32'h0, 32'd4, 4'b1000, 32'd16, 1'b0, 1'b0);
    run_op("illeg", 2'b10, 3'b010, 1'b0, 32'd5, 32'd6, 32'd7, 4'b0010, 32'h0, 1'b0, 1'b1);
    check("illeg.op1", alu_op1, 32'h0);
    check("illeg.op2", alu_op2, 32'h0);

    // Backpressure: R-type ADD 100+23, consumer stalls 5 cycles
    out_ready = 1'b0;
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0;
    rs1_data = 32'd100; rs2_data = 32'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.out_valid0", {31'h0, out_valid}, 32'h1);
    check("bp.result0", result, 32'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_op = 2'b11; funct3 = 3'b110; rs1_data = 32'hAAAA; imm = 32'h5555; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp.out_valid", {31'h0, out_valid}, 32'h1);
      check("bp.result", result, 32'd123);
      check("bp.in_ready", {31'h0, in_ready}, 32'h0);
      check("bp.ctrl_held", {28'h0, alu_control}, 32'h2);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt = (cnt + 1) % 8;
    check("bp.op_count_wrap", {29'h0, op_count}, cnt[31:0]);
    check("bp.in_ready_after", {31'h0, in_ready}, 32'h1);
    check("bp.out_valid_after", {31'h0, out_valid}, 32'h0);
    check("bp.result_kept", result, 32'd123);

    run_op("iand", 2'b11, 3'b111, 1'b1, 32'hF0F0, 32'h0, 32'hFF, 4'b0000, 32'hF0, 1'b0, 1'b0);

    // Reset asserted while in EXEC
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b1;
    rs1_data = 32'd10; rs2_data = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rx.ctrl_exec", {28'h0, alu_control}, 32'h6);
    rst_n = 1'b0;
    #1;
    check("rx.ctrl", {28'h0, alu_control}, 32'h0);
    check("rx.result", result, 32'h0);
    check("rx.out_valid", {31'h0, out_valid}, 32'h0);
    check("rx.in_ready", {31'h0, in_ready}, 32'h1);
    check("rx.op_count", {29'h0, op_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rx.no_out_valid", {31'h0, out_valid}, 32'h0);
      check("rx.op_count_post", {29'h0, op_count}, 32'h0);
    end

    run_op("ld", 2'b00, 3'b010, 1'b0, 32'h1000, 32'h0, 32'h24, 4'b0010, 32'h1024, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
